// File: rtl/debounce_sync_pkg.sv
// rtl/debounce_sync_pkg.sv - shared button constants for the debounce front end
package debounce_sync_pkg;

    localparam int CLK_FREQ_HZ = 50_000_000;
    localparam int DEBOUNCE_MS = 10;
    localparam int N_BUTTONS   = 4;

    localparam int BTN_FIRE  = 0;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_RIGHT = 2;
    localparam int BTN_START = 3;

    // Hold time in clock cycles; divide first so the product stays within 32 bits.
    function automatic int debounce_cycles(input int freq_hz, input int ms);
        return (freq_hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - two-flop synchroniser plus hold-time filter for one button
module debounce_channel #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
    parameter bit INVERT          = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic pressed
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             lvl;
    logic [CNT_W-1:0] count;

    assign lvl = sync2 ^ INVERT;

    always_ff @(posedge clk) begin
        if (reset) begin
            // Synchroniser flops clear to the pin value of a released button.
            sync1   <= INVERT;
            sync2   <= INVERT;
            count   <= '0;
            pressed <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (lvl == pressed) begin
                count <= '0;
            end else if (count == LAST) begin
                pressed <= lvl;
                count   <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - per-button synchronise and debounce array
module debounce_sync #(
    parameter int N_BUTTONS       = debounce_sync_pkg::N_BUTTONS,
    parameter int DEBOUNCE_CYCLES = debounce_sync_pkg::debounce_cycles(
                                        debounce_sync_pkg::CLK_FREQ_HZ,
                                        debounce_sync_pkg::DEBOUNCE_MS),
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_BUTTONS-1:0] raw_in,
    output logic [N_BUTTONS-1:0] pressed
);

    // Inversion happens after the synchroniser inside each channel so the
    // raw pin feeds the first flop directly.
    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .INVERT          (ACTIVE_LOW)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .raw     (raw_in[i]),
            .pressed (pressed[i])
        );
    end

endmodule

// File: tb/tb_debounce_sync.sv
// tb/tb_debounce_sync.sv - bench for debounce_sync, active-high and active-low instances
module tb_debounce_sync;

    localparam int D = 4;
    localparam int FIRE  = debounce_sync_pkg::BTN_FIRE;
    localparam int LEFT  = debounce_sync_pkg::BTN_LEFT;
    localparam int RIGHT = debounce_sync_pkg::BTN_RIGHT;
    localparam int START = debounce_sync_pkg::BTN_START;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] raw_h;
    logic [3:0] raw_l;
    logic [3:0] pressed_h;
    logic [3:0] pressed_l;

    int errors = 0;
    int checks = 0;

    // Reference model state, index 0 = active-high DUT, 1 = active-low DUT.
    logic [3:0] samp [2][2];   // raw samples from the last two edges, [0] newest
    logic [3:0] hist [2][D];   // button level seen by the filter on the last D edges
    logic [3:0] exp_p [2];

    always #5 clk = ~clk;

    debounce_sync #(.N_BUTTONS(4), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b0)) dut_h (
        .clk     (clk),
        .reset   (reset),
        .raw_in  (raw_h),
        .pressed (pressed_h)
    );

    debounce_sync #(.N_BUTTONS(4), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b1)) dut_l (
        .clk     (clk),
        .reset   (reset),
        .raw_in  (raw_l),
        .pressed (pressed_l)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, want);
        end
    endtask

    // A level is accepted once the filter has seen it, differing from the
    // current output, on D consecutive edges; the filter sees pins two edges late.
    task automatic model_edge(input int p, input logic [3:0] raw, input logic rst);
        logic [3:0] pol;
        logic [3:0] lvl;
        logic       all_differ;
        pol = (p == 1) ? 4'hF : 4'h0;
        if (rst) begin
            samp[p][0] = pol;
            samp[p][1] = pol;
            for (int i = 0; i < D; i++) hist[p][i] = 4'h0;
            exp_p[p] = 4'h0;
        end else begin
            lvl = samp[p][1] ^ pol;
            samp[p][1] = samp[p][0];
            samp[p][0] = raw;
            for (int i = D - 1; i > 0; i--) hist[p][i] = hist[p][i-1];
            hist[p][0] = lvl;
            for (int ch = 0; ch < 4; ch++) begin
                all_differ = 1'b1;
                for (int i = 0; i < D; i++)
                    if (hist[p][i][ch] == exp_p[p][ch]) all_differ = 1'b0;
                if (all_differ) exp_p[p][ch] = ~exp_p[p][ch];
            end
        end
    endtask

    task automatic cycle(input logic [3:0] rh, input logic [3:0] rl, input logic rst);
        raw_h = rh;
        raw_l = rl;
        reset = rst;
        @(posedge clk);
        model_edge(0, rh, rst);
        model_edge(1, rl, rst);
        #1;
        check("model_h", {28'd0, pressed_h}, {28'd0, exp_p[0]});
        check("model_l", {28'd0, pressed_l}, {28'd0, exp_p[1]});
    endtask

    initial begin
        logic [3:0] rh;
        logic [3:0] rl;
        logic       rst;

        // 1: reset with all buttons released
        for (int k = 0; k < 3; k++) begin
            cycle(4'h0, 4'hF, 1'b1);
            check("t1_reset_h", {28'd0, pressed_h}, 32'd0);
            check("t1_reset_l", {28'd0, pressed_l}, 32'd0);
        end
        for (int k = 0; k < 3; k++) begin
            cycle(4'h0, 4'hF, 1'b0);
            check("t1_idle_h", {28'd0, pressed_h}, 32'd0);
        end

        // 2: fire pressed and held
        for (int k = 1; k <= 8; k++) begin
            cycle(4'b0001 << FIRE, 4'hF, 1'b0);
            check("t2_fire", {31'd0, pressed_h[FIRE]}, {31'd0, k >= 6});
            check("t2_others", {29'd0, pressed_h[3:1]}, 32'd0);
        end
        for (int k = 0; k < 8; k++) cycle(4'h0, 4'hF, 1'b0);

        // 3: short pulse rejected, pulse of exactly D accepted
        for (int k = 0; k < 3; k++) cycle(4'b0001 << LEFT, 4'hF, 1'b0);
        for (int k = 0; k < 8; k++) begin
            cycle(4'h0, 4'hF, 1'b0);
            check("t3_short", {31'd0, pressed_h[LEFT]}, 32'd0);
        end
        for (int k = 0; k < 4; k++) cycle(4'b0001 << LEFT, 4'hF, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            cycle(4'h0, 4'hF, 1'b0);
            check("t3_exact", {31'd0, pressed_h[LEFT]}, {31'd0, (k >= 2) && (k <= 5)});
        end

        // 4: bouncing then settled high
        for (int j = 0; j < 20; j++) begin
            cycle(((j / 2) % 2 == 0) ? (4'b0001 << RIGHT) : 4'h0, 4'hF, 1'b0);
            check("t4_bounce", {31'd0, pressed_h[RIGHT]}, 32'd0);
        end
        for (int k = 1; k <= 8; k++) begin
            cycle(4'b0001 << RIGHT, 4'hF, 1'b0);
            check("t4_settle", {31'd0, pressed_h[RIGHT]}, {31'd0, k >= 6});
        end
        for (int k = 0; k < 8; k++) cycle(4'h0, 4'hF, 1'b0);

        // 5: reset while start's counter is part way
        for (int k = 0; k < 5; k++) cycle(4'b0001 << START, 4'hF, 1'b0);
        cycle(4'b0001 << START, 4'hF, 1'b1);
        check("t5_in_reset", {31'd0, pressed_h[START]}, 32'd0);
        for (int k = 1; k <= 8; k++) begin
            cycle(4'b0001 << START, 4'hF, 1'b0);
            check("t5_after_reset", {31'd0, pressed_h[START]}, {31'd0, k >= 6});
        end

        // 6: active-low instance
        cycle(4'h0, 4'hF, 1'b1);
        check("t6_reset_l", {28'd0, pressed_l}, 32'd0);
        for (int k = 1; k <= 8; k++) begin
            cycle(4'h0, 4'hF & ~(4'b0001 << FIRE), 1'b0);
            check("t6_fire_l", {31'd0, pressed_l[FIRE]}, {31'd0, k >= 6});
            check("t6_others_l", {29'd0, pressed_l[3:1]}, 32'd0);
        end

        // Random pin activity with occasional reset, checked against the model.
        rh = 4'h0;
        rl = 4'hF;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(4) == 0) rh[$urandom_range(3)] ^= 1'b1;
            if ($urandom_range(4) == 0) rl[$urandom_range(3)] ^= 1'b1;
            rst = ($urandom_range(99) == 0);
            cycle(rh, rl, rst);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
